timer_ctrl8: RTL
================

# timer_ctrl8

Controller and sequencer for an 8-bit up-counter datapath. It holds the counter's configuration: load value, compare value, prescaler and reload mode. It runs the counter through start, pause, stop and terminal-count events, and reports status to the surrounding logic. It sits between a simple register/command interface and the counter. It is the block the rest of the design uses whenever a timed interval or a periodic tick is needed.

## Interface
- PRESC_W, 8, width of the prescaler divisor register and internal prescale counter.

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  configuration write strobe; accepted only in IDLE or DONE
- cfg_load  in  8  count value loaded on start and on auto-reload
- cfg_cmp  in  8  terminal compare value
- cfg_presc  in  PRESC_W  prescale divisor minus one (0 = tick every cycle)
- cfg_auto  in  1  1 = periodic (auto-reload), 0 = one-shot
- start  in  1  single-cycle command: begin counting
- stop  in  1  single-cycle command: abort counting
- hold  in  1  level: pause counting while high
- count  out  8  current counter value (registered)
- busy  out  1  high in RUN or PAUSE
- match  out  1  one-cycle pulse per terminal-count event
- done  out  1  high while in DONE (one-shot finished)

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (async, rst=1):
  - State goes to IDLE.
  - Outputs: count=0, busy=0, match=0, done=0.
  - Internal registers: load_r=0, cmp_r=8'hFF, presc_r=0, auto_r=0, presc_cnt=0.
- cfg_we=1 in IDLE/DONE: load_r, cmp_r, presc_r and auto_r capture their inputs. cfg_we is ignored in RUN/PAUSE.
- start in IDLE/DONE:
  - count<=load_r, presc_cnt<=0, done<=0; go to RUN.
  - start is ignored in RUN/PAUSE; there is no restart.
- RUN, each cycle with no stop/hold:
  - presc_cnt increments.
  - When presc_cnt==presc_r, a tick occurs and presc_cnt<=0.
- On a tick:
  - If count==cmp_r, this is a terminal event: match<=1 for one cycle.
    - auto_r=1: count<=load_r, stay in RUN.
    - auto_r=0: count holds at cmp_r, go to DONE, done<=1, busy<=0.
  - Otherwise count<=count+1, modulo 256. 8'hFF wraps to 8'h00 and counting continues.
- load_r > cmp_r is legal: the count wraps through 0 before reaching cmp_r.
- load_r==cmp_r: every tick is a terminal event.
- Ticks per period = ((cmp_r - load_r) mod 256) + 1.
- Cycles per period = ticks per period × (presc_r+1).
- hold=1 in RUN: go to PAUSE. count and presc_cnt are frozen, no tick, busy stays 1.
- PAUSE with hold=0: return to RUN and resume from the frozen count/presc_cnt.
- stop in RUN/PAUSE:
  - Go to IDLE, busy<=0, count frozen at its current value, no match.
  - stop in IDLE/DONE has no effect.
- Priority in RUN/PAUSE: stop > hold > tick.
- Priority in IDLE/DONE: start is acted on; stop is ignored.
- Same-cycle cfg_we and start in IDLE/DONE: the configuration is written first, and start uses the new cfg_load.
- DONE holds count=cmp_r and done=1 until start, or until rst.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- start sampled at edge N:
  - count=load_r and busy=1 are visible after edge N.
  - The first tick can occur at edge N+1 + presc_r.
- match is asserted for exactly one cycle, after the edge at which the terminal tick is taken. In the same cycle, count shows the reloaded value (auto) or cmp_r (one-shot).
- hold/stop take effect at the edge where they are sampled. A tick due on that edge is suppressed.
- Asserting rst mid-operation clears immediately, with no wait for the clock. The block is in IDLE on the first edge after rst deasserts.

## Test plan
- Reset then idle: rst pulse -> count=0, busy=0, match=0, done=0 for 10 cycles.
- One-shot: load=0, cmp=3, presc=0, auto=0, start ->
  - count 0,1,2,3 on successive cycles;
  - match pulse one cycle after count first shows 3;
  - done=1, busy=0, count stays 3.
- Periodic with prescale: load=2, cmp=4, presc=1, auto=1 ->
  - each count value is held 2 cycles;
  - match every 6 cycles;
  - count sequence 2,3,4,2,…
- Wrap-around: load=8'hFE, cmp=8'h01, presc=0, auto=0 -> count FE,FF,00,01, then DONE; 4 ticks.
- Hold and stop:
  - While running, hold high 5 cycles -> count frozen, busy=1, then resumes at the same value.
  - stop asserted together with hold -> IDLE, busy=0, no match.
- Ignored commands and async reset:
  - cfg_we and start during RUN -> no config change, no restart.
  - rst asserted between edges mid-RUN -> outputs clear immediately to their reset values.

Source files
------------

// File: rtl/timer_ctrl8_if.sv
// Command/configuration and status bundle between a timer user and timer_ctrl8.
// The master drives configuration and commands; the slave (the timer) returns status.
interface timer_ctrl8_if #(
    parameter int PRESC_W = 8
);
    logic               cfg_we;
    logic [7:0]         cfg_load;
    logic [7:0]         cfg_cmp;
    logic [PRESC_W-1:0] cfg_presc;
    logic               cfg_auto;
    logic               start;
    logic               stop;
    logic               hold;
    logic [7:0]         count;
    logic               busy;
    logic               match;
    logic               done;

    modport master (
        output cfg_we, cfg_load, cfg_cmp, cfg_presc, cfg_auto,
        output start, stop, hold,
        input  count, busy, match, done
    );

    modport slave (
        input  cfg_we, cfg_load, cfg_cmp, cfg_presc, cfg_auto,
        input  start, stop, hold,
        output count, busy, match, done
    );
endinterface

// File: rtl/timer_ctrl8.sv
// 8-bit prescaled up-counter sequencer: one-shot or periodic intervals with
// pause/abort control and a one-cycle match pulse on every terminal count.
module timer_ctrl8 #(
    parameter int PRESC_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl8_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [7:0]         r_count,     w_count_nxt;
    logic [7:0]         r_load,      w_load_nxt;
    logic [7:0]         r_cmp,       w_cmp_nxt;
    logic [PRESC_W-1:0] r_presc,     w_presc_nxt;
    logic [PRESC_W-1:0] r_presc_cnt, w_presc_cnt_nxt;
    logic               r_auto,      w_auto_nxt;
    logic               r_match,     w_match_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_done,      w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 8'h00;
            r_load      <= 8'h00;
            r_cmp       <= 8'hFF;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_auto      <= 1'b0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_load      <= w_load_nxt;
            r_cmp       <= w_cmp_nxt;
            r_presc     <= w_presc_nxt;
            r_presc_cnt <= w_presc_cnt_nxt;
            r_auto      <= w_auto_nxt;
            r_match     <= w_match_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_load_nxt      = r_load;
        w_cmp_nxt       = r_cmp;
        w_presc_nxt     = r_presc;
        w_presc_cnt_nxt = r_presc_cnt;
        w_auto_nxt      = r_auto;
        w_match_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.cfg_we) begin
                    w_load_nxt  = bus.cfg_load;
                    w_cmp_nxt   = bus.cfg_cmp;
                    w_presc_nxt = bus.cfg_presc;
                    w_auto_nxt  = bus.cfg_auto;
                end
                // A same-cycle configuration write feeds the start load directly.
                if (bus.start) begin
                    w_count_nxt     = bus.cfg_we ? bus.cfg_load : r_load;
                    w_presc_cnt_nxt = '0;
                    w_state_nxt     = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.hold) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_presc_cnt == r_presc) begin
                    w_presc_cnt_nxt = '0;
                    if (r_count == r_cmp) begin
                        w_match_nxt = 1'b1;
                        if (r_auto) begin
                            w_count_nxt = r_load;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_count_nxt = r_count + 8'd1;
                    end
                end else begin
                    w_presc_cnt_nxt = r_presc_cnt + 1'b1;
                end
            end
            S_PAUSE: begin
                // Leaving PAUSE only re-enters RUN; counting resumes on the next edge.
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!bus.hold) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.match = r_match;
    assign bus.done  = r_done;

endmodule
